// File: rtl/key_step_ctrl_pkg.sv
// Shared definitions for the key/step controller: debouncer state encoding and synchroniser depth.
`timescale 1ns/1ps
package key_step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

    localparam int SYNC_DEPTH = 2;

    // A key counts as held from the accepted press until the release is accepted.
    function automatic logic state_is_held(input deb_state_e st);
        return (st == PRESSED) || (st == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/key_step_ctrl_debounce.sv
// Debouncer for one synchronised active-low key: press/release each need DEBOUNCE_CYCLES stable cycles.
`timescale 1ns/1ps
module key_debounce
    import key_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
)(
    input  logic clock,
    input  logic reset,
    input  logic s_in,
    output logic held,
    output logic press_pulse
);

    localparam int              CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!s_in) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (s_in) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (s_in) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back low during release resumes the press without a new pulse.
                if (!s_in) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign held        = state_is_held(state_q);
    assign press_pulse = pulse_q;

endmodule

// File: rtl/key_step_ctrl.sv
// Board key/switch front end for the multicycle core: sync, debounce, step enable and processor reset.
// Optional auto-step generator is built when KEY_AUTOSTEP_EN is defined.
`timescale 1ns/1ps
module key_step_ctrl
    import key_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
`ifdef KEY_AUTOSTEP_EN
    ,
    parameter int AUTO_PERIOD     = 64
`endif
)(
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       key_raw,
    input  logic [2:0]       sw_raw,
    output logic             step_pulse,
    output logic             proc_reset_n,
    output logic [2:0]       sw_sync,
    output logic [1:0]       key_held,
    output logic [CNT_W-1:0] step_count
);

    logic [SYNC_DEPTH-1:0][1:0] key_sync_q, key_sync_d;
    logic [SYNC_DEPTH-1:0][2:0] sw_sync_q, sw_sync_d;
    logic [1:0]                 held_w;
    logic [1:0]                 press_w;
    logic                       proc_reset_n_q, proc_reset_n_d;
    logic [CNT_W-1:0]           step_count_q, step_count_d;
    logic                       rst_req;
    logic                       step_req;
    logic                       step_fire;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
        .clock       (clock),
        .reset       (reset),
        .s_in        (key_sync_q[SYNC_DEPTH-1][0]),
        .held        (held_w[0]),
        .press_pulse (press_w[0])
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
        .clock       (clock),
        .reset       (reset),
        .s_in        (key_sync_q[SYNC_DEPTH-1][1]),
        .held        (held_w[1]),
        .press_pulse (press_w[1])
    );

    // Processor reset request covers the lagging cycle where key0 is already held but
    // proc_reset_n_q has not fallen yet, so a same-cycle key1 press loses to reset.
    always_comb begin
        key_sync_d     = {key_sync_q[SYNC_DEPTH-2:0], key_raw};
        sw_sync_d      = {sw_sync_q[SYNC_DEPTH-2:0], sw_raw};
        rst_req        = !proc_reset_n_q || held_w[0];
        proc_reset_n_d = !held_w[0];
        step_fire      = step_req && !rst_req;
        step_count_d   = rst_req ? '0 : step_count_q + CNT_W'(step_fire);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_sync_q     <= {SYNC_DEPTH{2'b11}};
            sw_sync_q      <= '0;
            proc_reset_n_q <= 1'b0;
            step_count_q   <= '0;
        end else begin
            key_sync_q     <= key_sync_d;
            sw_sync_q      <= sw_sync_d;
            proc_reset_n_q <= proc_reset_n_d;
            step_count_q   <= step_count_d;
        end
    end

`ifdef KEY_AUTOSTEP_EN
    localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

    logic [AW-1:0] auto_cnt_q, auto_cnt_d;
    logic          auto_fire_q, auto_fire_d;

    // Counter idles at zero whenever auto mode is off, so each enable starts a fresh period.
    always_comb begin
        auto_cnt_d  = '0;
        auto_fire_d = 1'b0;
        if (sw_sync_q[SYNC_DEPTH-1][2] && !rst_req) begin
            if (auto_cnt_q == AW'(AUTO_PERIOD - 1)) begin
                auto_fire_d = 1'b1;
            end else begin
                auto_cnt_d = auto_cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            auto_cnt_q  <= '0;
            auto_fire_q <= 1'b0;
        end else begin
            auto_cnt_q  <= auto_cnt_d;
            auto_fire_q <= auto_fire_d;
        end
    end

    assign step_req = press_w[1] | auto_fire_q;
`else
    assign step_req = press_w[1];
`endif

    // step_pulse is a single-cycle enable with no back-pressure: the core must accept it when high.
    assign step_pulse   = step_fire;
    assign proc_reset_n = proc_reset_n_q;
    assign sw_sync      = sw_sync_q[SYNC_DEPTH-1];
    assign key_held     = held_w;
    assign step_count   = step_count_q;

endmodule

// File: tb/tb_key_step_ctrl.sv
// Directed bench for key_step_ctrl; step timing scored against an expected-cycle queue.
`timescale 1ns/1ps
module tb_key_step_ctrl;

  logic        clock;
  logic        reset;
  logic [1:0]  key_raw, key_raw_w;
  logic [2:0]  sw_raw, sw_raw_w;

  logic        step_pulse, proc_reset_n;
  logic [2:0]  sw_sync;
  logic [1:0]  key_held;
  logic [15:0] step_count;

  logic        step_pulse_w, proc_reset_n_w;
  logic [2:0]  sw_sync_w;
  logic [1:0]  key_held_w;
  logic [3:0]  step_count_w;

  int          errors = 0;
  int          checks = 0;
  int          pulses_w = 0;
  logic [31:0] cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_stamp;
  logic [31:0] c;

  key_step_ctrl #(.DEBOUNCE_CYCLES(16), .CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .key_raw      (key_raw),
    .sw_raw       (sw_raw),
    .step_pulse   (step_pulse),
    .proc_reset_n (proc_reset_n),
    .sw_sync      (sw_sync),
    .key_held     (key_held),
    .step_count   (step_count)
  );

  // Narrow counter instance so the wrap can be reached in a few presses.
  key_step_ctrl #(.DEBOUNCE_CYCLES(16), .CNT_W(4)) dut_w (
    .clock        (clock),
    .reset        (reset),
    .key_raw      (key_raw_w),
    .sw_raw       (sw_raw_w),
    .step_pulse   (step_pulse_w),
    .proc_reset_n (proc_reset_n_w),
    .sw_sync      (sw_sync_w),
    .key_held     (key_held_w),
    .step_count   (step_count_w)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic press_w();
    key_raw_w = 2'b01;
    tick(20);
    key_raw_w = 2'b11;
    tick(22);
  endtask

  // scoreboard: every step_pulse must match the next expected cycle stamp
  always @(negedge clock) begin
    if (step_pulse === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL step_unexpected: observed pulse at cycle %0d expected none", cyc);
      end
      if (exp_q.size() != 0) begin
        exp_stamp = exp_q.pop_front();
        assert (cyc === exp_stamp) else begin
          errors++;
          $error("FAIL step_timing: observed cycle=%0d expected cycle=%0d", cyc, exp_stamp);
        end
      end
    end
    if (step_pulse_w === 1'b1) pulses_w++;
  end

  initial begin
    reset     = 1'b0;
    key_raw   = 2'b11;
    key_raw_w = 2'b11;
    sw_raw    = 3'b011;
    sw_raw_w  = 3'b000;

    // reset state
    #20;
    check("rst_proc_reset_n", 32'(proc_reset_n), 32'h0);
    check("rst_step_pulse",   32'(step_pulse),   32'h0);
    check("rst_key_held",     32'(key_held),     32'h0);
    check("rst_step_count",   32'(step_count),   32'h0);
    check("rst_sw_sync",      32'(sw_sync),      32'h0);
    #21;
    reset = 1'b1;

    // first edge after release
    tick(1);
    check("rel_proc_reset_n", 32'(proc_reset_n), 32'h1);
    check("rel_step_pulse",   32'(step_pulse),   32'h0);
    check("rel_step_count",   32'(step_count),   32'h0);
    check("sw_sync_lat1",     32'(sw_sync),      32'h0);
    tick(1);
    check("sw_sync_lat2",     32'(sw_sync),      32'h3);

    // clean key1 press held 40 cycles
    c = cyc;
    key_raw = 2'b01;
    exp_q.push_back(c + 19);
    tick(18);
    check("press_held_early", 32'(key_held), 32'h0);
    tick(1);
    check("press_step_pulse", 32'(step_pulse), 32'h1);
    check("press_held",       32'(key_held),   32'h2);
    tick(21);
    key_raw = 2'b11;
    tick(18);
    check("release_held_late", 32'(key_held), 32'h2);
    tick(1);
    check("release_held_drop", 32'(key_held), 32'h0);
    check("press_step_count",  32'(step_count), 32'h1);

    // bounce shorter than the debounce window
    key_raw = 2'b01; tick(5);
    key_raw = 2'b11; tick(3);
    key_raw = 2'b01; tick(5);
    key_raw = 2'b11; tick(40);
    check("bounce_step_count", 32'(step_count), 32'h1);
    check("bounce_key_held",   32'(key_held),   32'h0);

    // key0 and key1 together: reset wins
    c = cyc;
    key_raw = 2'b00;
    tick(19);
    check("both_key_held",   32'(key_held),   32'h3);
    check("both_step_pulse", 32'(step_pulse), 32'h0);
    tick(1);
    check("both_proc_reset_n", 32'(proc_reset_n), 32'h0);
    check("both_step_count",   32'(step_count),   32'h0);
    tick(10);
    check("hold_proc_reset_n", 32'(proc_reset_n), 32'h0);
    key_raw = 2'b11;
    tick(19);
    check("exit_proc_reset_late", 32'(proc_reset_n), 32'h0);
    tick(1);
    check("exit_proc_reset_n",    32'(proc_reset_n), 32'h1);
    check("exit_step_count",      32'(step_count),   32'h0);

    // counter wrap on the 4-bit instance
    for (int i = 0; i < 15; i++) press_w();
    check("wrap_count_max",  32'(step_count_w), 32'hF);
    press_w();
    check("wrap_count_zero", 32'(step_count_w), 32'h0);

`ifdef KEY_AUTOSTEP_EN
    // auto-step: sw_sync[2] rises two edges after the drive
    c = cyc;
    sw_raw = 3'b111;
    for (int k = 1; k <= 4; k++) exp_q.push_back(c + 2 + 64 * k);
    tick(300);
    sw_raw = 3'b011;
    tick(100);
    check("auto_step_count", 32'(step_count), 32'h4);
`else
    sw_raw = 3'b111;
    tick(1);
    check("sw2_pass_lat1", 32'(sw_sync), 32'h3);
    tick(1);
    check("sw2_pass_lat2", 32'(sw_sync), 32'h7);
    tick(100);
    check("sw2_no_auto_count", 32'(step_count), 32'h0);
    sw_raw = 3'b011;
    tick(2);
    check("sw2_pass_fall", 32'(sw_sync), 32'h3);
`endif

    check("missing_steps",   32'(exp_q.size()), 32'h0);
    check("wrap_pulses",     32'(pulses_w),     32'd16);
    check("wrap_key_held",   32'(key_held_w),   32'h0);
    check("wrap_proc_reset", 32'(proc_reset_n_w), 32'h1);
    check("wrap_sw_sync",    32'(sw_sync_w),    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
